// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display path (scan controller and
// decoder wrapper).
//   DIGIT_W      width of one hex digit
//   MAX_DIGITS   largest supported bank; digit index is 3 bits wide
//   ANODE_OFF    all anodes released (active-low enables)
//   digit_nibble extract digit i from a MAX_DIGITS-wide packed value
package disp_pkg;
  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // Digit i lives at bits [4i+3:4i]; {i,2'b00} is i*DIGIT_W for DIGIT_W == 4.
  function automatic logic [DIGIT_W-1:0] digit_nibble(
    input logic [MAX_DIGITS*DIGIT_W-1:0] v,
    input logic [2:0]                    i
  );
    return v[{i, 2'b00} +: DIGIT_W];
  endfunction
endpackage

// File: rtl/display_scan_ctrl_if.sv
// Host-side bundle of the scan controller.
//   value_in/load/lz_blank : host -> controller
//   disp_num/an/digit_idx/frame_tick : controller -> decoder / host
// master = host/bench side, slave = display_scan_ctrl.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
) ();
  import disp_pkg::*;

  logic [NUM_DIGITS*DIGIT_W-1:0] value_in;
  logic                          load;
  logic                          lz_blank;
  logic [DIGIT_W-1:0]            disp_num;
  logic [NUM_DIGITS-1:0]         an;
  logic [2:0]                    digit_idx;
  logic                          frame_tick;

  modport master (
    output value_in, load, lz_blank,
    input  disp_num, an, digit_idx, frame_tick
  );

  modport slave (
    input  value_in, load, lz_blank,
    output disp_num, an, digit_idx, frame_tick
  );
endinterface

// File: rtl/clk_en_divider.sv
// Free-running prescaler: count runs 0..DIV-1 and wraps; tc is high while
// count sits at its terminal value DIV-1.
//   clk, rst (sync, active-high) ; count ; tc
module clk_en_divider #(
  parameter  int DIV = 2,
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] count,
  output logic          tc
);
  assign tc = (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)     count <= '0;
    else if (tc) count <= '0;
    else         count <= count + CW'(1);
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// Holds a hex value, scans one digit per refresh slot, drives active-low
// anodes and the nibble for the shared hex-to-segment decoder.
//   clk, rst (sync, active-high)
//   bus.value_in/load  : capture a new value (shown from the next frame on)
//   bus.lz_blank       : suppress leading zeros (digit 0 always shown)
//   bus.disp_num/an    : registered decoder nibble and anode enables
//   bus.digit_idx      : digit currently scanned
//   bus.frame_tick     : pulse in the first cycle of each new frame
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  display_scan_ctrl_if.slave bus
);
  localparam int         CW   = $clog2(REFRESH_DIV);
  localparam int         VW   = NUM_DIGITS * DIGIT_W;
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS)
      $error("display_scan_ctrl: NUM_DIGITS must be 1..%0d", MAX_DIGITS);
    if (REFRESH_DIV < 2)
      $error("display_scan_ctrl: REFRESH_DIV must be >= 2");
    if (GUARD_CYCLES < 0 || GUARD_CYCLES >= REFRESH_DIV)
      $error("display_scan_ctrl: GUARD_CYCLES must be 0..REFRESH_DIV-1");
  endgenerate

  // Slot prescaler
  logic [CW-1:0] cnt;
  logic          tc;

  clk_en_divider #(.DIV(REFRESH_DIV)) u_div (
    .clk   (clk),
    .rst   (rst),
    .count (cnt),
    .tc    (tc)
  );

  // Digit index; wrap marks the last cycle of a frame
  logic [2:0] idx;
  logic       wrap;

  assign wrap = tc && (idx == LAST);

  always_ff @(posedge clk) begin
    if (rst)     idx <= '0;
    else if (tc) idx <= (idx == LAST) ? 3'd0 : idx + 3'd1;
  end

  // Double-buffered value: loads land in pending and only move to the
  // displayed copy at a frame boundary, so a frame never mixes two values.
  // A load on the wrap cycle itself goes straight through.
  logic [VW-1:0] pending, active;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      active  <= '0;
    end else begin
      if (bus.load) pending <= bus.value_in;
      if (wrap)     active  <= bus.load ? bus.value_in : pending;
    end
  end

  logic [MAX_DIGITS*DIGIT_W-1:0] act_ext;

  always_comb begin
    act_ext         = '0;
    act_ext[VW-1:0] = active;
  end

  // Leading-zero mask: walk down from the top digit while everything seen so
  // far is zero. Digit 0 is never blanked.
  logic [MAX_DIGITS-1:0] blank;
  logic                  all_zero;

  always_comb begin
    blank    = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (act_ext[i*DIGIT_W +: DIGIT_W] == '0);
      blank[i] = bus.lz_blank && all_zero;
    end
  end

  // Registered outputs (one cycle behind cnt/idx). Anodes stay off for the
  // first GUARD_CYCLES of each slot so the shared seg bus can settle.
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_on;
  logic [NUM_DIGITS-1:0] an_q;
  logic [DIGIT_W-1:0]    dnum_q;
  logic                  ftick_q;

  assign lit   = (cnt >= CW'(GUARD_CYCLES)) && !blank[idx];
  assign an_on = ~(NUM_DIGITS'(1) << idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q    <= NUM_DIGITS'(ANODE_OFF);
      dnum_q  <= '0;
      ftick_q <= 1'b0;
    end else begin
      an_q    <= lit ? an_on : NUM_DIGITS'(ANODE_OFF);
      dnum_q  <= blank[idx] ? '0 : digit_nibble(act_ext, idx);
      ftick_q <= wrap;
    end
  end

  assign bus.an         = an_q;
  assign bus.disp_num   = dnum_q;
  assign bus.frame_tick = ftick_q;
  assign bus.digit_idx  = idx;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: NUM_DIGITS=4, REFRESH_DIV=8,
// GUARD_CYCLES=2 (8-cycle slots, 32-cycle frames).
module tb_display_scan_ctrl;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (8),
    .GUARD_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // At most one anode low in any cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ($countones(~bus.an) > 1) begin
        errors++;
        $display("FAIL onehot: an=%b has more than one low bit", bus.an);
      end
    end
  end

  // Per-frame observations (slot s sampled mid-lit, cnt=4)
  logic [3:0] obs_an [4];
  logic [3:0] obs_dn [4];
  logic [2:0] obs_idx[4];
  int         lit_cnt[4];
  int         ft_mid;
  logic       ft_end;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.value_in = v;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  // Advance until frame_tick is seen (cycle 0 of slot 0), bounded.
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.frame_tick !== 1'b1 && n < 64);
    checks++;
    if (bus.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame: frame_tick=%b after %0d cycles, required 1", bus.frame_tick, n);
    end
  endtask

  // Called at cycle 0 of a frame; records one full frame and ends at cycle 0
  // of the next one.
  task automatic observe_frame();
    for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
    ft_mid = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if ((c - 1) % 8 == 4) begin
        obs_an [(c - 1) / 8] = bus.an;
        obs_dn [(c - 1) / 8] = bus.disp_num;
        obs_idx[(c - 1) / 8] = bus.digit_idx;
      end
      for (int d = 0; d < 4; d++) if (bus.an[d] === 1'b0) lit_cnt[d]++;
      if (c < 32 && bus.frame_tick === 1'b1) ft_mid++;
    end
    ft_end = bus.frame_tick;
  endtask

  task automatic test_reset();
    do_load(16'h1234);
    wait_frame();
    repeat (13) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want f", bus.an); end
    end
    checks += 3;
    if (bus.disp_num !== 4'h0) begin errors++; $display("FAIL reset_dn: got %h want 0", bus.disp_num); end
    if (bus.digit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.digit_idx); end
    if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft: got %b want 0", bus.frame_tick); end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.an !== 4'hF) begin errors++; $display("FAIL reset_guard: cycle2 an got %h want f", bus.an); end
    tick();
    checks += 3;
    if (bus.an !== 4'hE) begin errors++; $display("FAIL reset_first_lit: cycle3 an got %h want e", bus.an); end
    if (bus.disp_num !== 4'h0) begin errors++; $display("FAIL reset_active_cleared: dn got %h want 0", bus.disp_num); end
    if (bus.digit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx_slot0: got %0d want 0", bus.digit_idx); end
    repeat (28) tick();
    checks++;
    if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft_early: cycle31 got %b want 0", bus.frame_tick); end
    tick();
    checks++;
    if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL reset_ft_32: cycle32 got %b want 1", bus.frame_tick); end
  endtask

  task automatic test_scan_order();
    logic [3:0] e_an[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] e_dn[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    do_load(16'h1234);
    wait_frame();
    observe_frame();
    for (int s = 0; s < 4; s++) begin
      checks += 4;
      if (obs_an[s] !== e_an[s]) begin errors++; $display("FAIL scan_an slot%0d: got %h want %h", s, obs_an[s], e_an[s]); end
      if (obs_dn[s] !== e_dn[s]) begin errors++; $display("FAIL scan_dn slot%0d: got %h want %h", s, obs_dn[s], e_dn[s]); end
      if (obs_idx[s] !== 3'(s)) begin errors++; $display("FAIL scan_idx slot%0d: got %0d want %0d", s, obs_idx[s], s); end
      if (lit_cnt[s] != 6) begin errors++; $display("FAIL scan_lit digit%0d: got %0d cycles want 6", s, lit_cnt[s]); end
    end
    checks += 2;
    if (ft_mid != 0) begin errors++; $display("FAIL scan_ft_mid: got %0d pulses want 0", ft_mid); end
    if (ft_end !== 1'b1) begin errors++; $display("FAIL scan_ft_period: got %b want 1 at cycle 32", ft_end); end
  endtask

  task automatic test_tear_free();
    logic [3:0] e_an[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] e_dn[4] = '{4'hD, 4'hC, 4'hB, 4'hA};
    repeat (12) tick();
    do_load(16'hABCD);
    checks += 2;
    if (bus.an !== 4'hD || bus.disp_num !== 4'h3) begin errors++; $display("FAIL tear_slot1: an=%h dn=%h want d/3", bus.an, bus.disp_num); end
    repeat (8) tick();
    if (bus.an !== 4'hB || bus.disp_num !== 4'h2) begin errors++; $display("FAIL tear_slot2: an=%h dn=%h want b/2", bus.an, bus.disp_num); end
    repeat (8) tick();
    checks++;
    if (bus.an !== 4'h7 || bus.disp_num !== 4'h1) begin errors++; $display("FAIL tear_slot3: an=%h dn=%h want 7/1", bus.an, bus.disp_num); end
    repeat (3) tick();
    checks++;
    if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL tear_ft: got %b want 1", bus.frame_tick); end
    observe_frame();
    for (int s = 0; s < 4; s++) begin
      checks += 2;
      if (obs_an[s] !== e_an[s]) begin errors++; $display("FAIL tear_next_an slot%0d: got %h want %h", s, obs_an[s], e_an[s]); end
      if (obs_dn[s] !== e_dn[s]) begin errors++; $display("FAIL tear_next_dn slot%0d: got %h want %h", s, obs_dn[s], e_dn[s]); end
    end
  endtask

  task automatic test_wrap_collision();
    logic [3:0] e_dn[4] = '{4'h0, 4'hF, 4'h0, 4'h0};
    repeat (31) tick();
    bus.value_in = 16'h00F0;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
    checks++;
    if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL wrap_ft: got %b want 1", bus.frame_tick); end
    observe_frame();
    for (int s = 0; s < 4; s++) begin
      checks += 2;
      if (obs_dn[s] !== e_dn[s]) begin errors++; $display("FAIL wrap_dn slot%0d: got %h want %h", s, obs_dn[s], e_dn[s]); end
      if (lit_cnt[s] != 6) begin errors++; $display("FAIL wrap_lit digit%0d: got %0d want 6", s, lit_cnt[s]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e_dn[4] = '{4'h6, 4'h7, 4'h8, 4'h9};
    do_load(16'h5555);
    do_load(16'h9876);
    wait_frame();
    observe_frame();
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (obs_dn[s] !== e_dn[s]) begin errors++; $display("FAIL b2b_dn slot%0d: got %h want %h", s, obs_dn[s], e_dn[s]); end
    end
  endtask

  task automatic test_leading_zeros();
    logic [3:0] a1[4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    logic [3:0] d1[4] = '{4'h0, 4'h7, 4'h0, 4'h0};
    int         l1[4] = '{6, 6, 0, 0};
    logic [3:0] a2[4] = '{4'hE, 4'hF, 4'hF, 4'hF};
    int         l2[4] = '{6, 0, 0, 0};
    logic [3:0] a3[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    bus.lz_blank = 1'b1;
    do_load(16'h0070);
    wait_frame();
    observe_frame();
    for (int s = 0; s < 4; s++) begin
      checks += 3;
      if (obs_an[s] !== a1[s]) begin errors++; $display("FAIL lz70_an slot%0d: got %h want %h", s, obs_an[s], a1[s]); end
      if (obs_dn[s] !== d1[s]) begin errors++; $display("FAIL lz70_dn slot%0d: got %h want %h", s, obs_dn[s], d1[s]); end
      if (lit_cnt[s] != l1[s]) begin errors++; $display("FAIL lz70_lit digit%0d: got %0d want %0d", s, lit_cnt[s], l1[s]); end
    end
    do_load(16'h0000);
    wait_frame();
    observe_frame();
    for (int s = 0; s < 4; s++) begin
      checks += 3;
      if (obs_an[s] !== a2[s]) begin errors++; $display("FAIL lz00_an slot%0d: got %h want %h", s, obs_an[s], a2[s]); end
      if (obs_dn[s] !== 4'h0) begin errors++; $display("FAIL lz00_dn slot%0d: got %h want 0", s, obs_dn[s]); end
      if (lit_cnt[s] != l2[s]) begin errors++; $display("FAIL lz00_lit digit%0d: got %0d want %0d", s, lit_cnt[s], l2[s]); end
    end
    bus.lz_blank = 1'b0;
    observe_frame();
    for (int s = 0; s < 4; s++) begin
      checks += 2;
      if (obs_an[s] !== a3[s]) begin errors++; $display("FAIL lzoff_an slot%0d: got %h want %h", s, obs_an[s], a3[s]); end
      if (lit_cnt[s] != 6) begin errors++; $display("FAIL lzoff_lit digit%0d: got %0d want 6", s, lit_cnt[s]); end
    end
  endtask

  initial begin
    bus.value_in = '0;
    bus.load     = 1'b0;
    bus.lz_blank = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    test_reset();
    test_scan_order();
    test_tear_free();
    test_wrap_collision();
    test_back_to_back();
    test_leading_zeros();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
